// File: rtl/aes_top_pack.sv
// Shared types and helpers for the header adder/remover pair.
// Header words are taken MSB word first so both sides agree on beat order.
package aes_top_pack;

    localparam int HEADER_BITS_DEF = 256;
    localparam int HDR_MAX_BITS    = 1024;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HEADER  = 2'd1,
        PAYLOAD = 2'd2,
        DROP    = 2'd3
    } header_remover_state_t;

    // Word idx of a hdr_bits-wide header, returned in the low data_w bits.
    function automatic logic [HDR_MAX_BITS-1:0] hdr_word(
        input logic [HDR_MAX_BITS-1:0] header,
        input int                      hdr_bits,
        input int                      data_w,
        input int                      idx
    );
        return header >> (hdr_bits - (idx + 1) * data_w);
    endfunction

endpackage

// File: rtl/st_reg_slice.sv
// Single-entry streaming register slice: data/sop/eop held until taken downstream.
// Latency 1 cycle; push_rdy = ~full | src_rdy, so no valid->ready combinational path.
// Backpressure: holds contents stable while src_rdy is low.
module st_reg_slice #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push_vld,
    input  logic [DATA_W-1:0] push_dat,
    input  logic              push_sop,
    input  logic              push_eop,
    output logic              push_rdy,
    output logic              src_vld,
    output logic [DATA_W-1:0] src_dat,
    output logic              src_sop,
    output logic              src_eop,
    input  logic              src_rdy
);

    logic              vld_q;
    logic [DATA_W-1:0] dat_q;
    logic              sop_q;
    logic              eop_q;

    assign push_rdy = ~vld_q | src_rdy;
    assign src_vld  = vld_q;
    assign src_dat  = dat_q;
    assign src_sop  = sop_q;
    assign src_eop  = eop_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_q <= 1'b0;
            dat_q <= '0;
            sop_q <= 1'b0;
            eop_q <= 1'b0;
        end else if (push_vld && push_rdy) begin
            vld_q <= 1'b1;
            dat_q <= push_dat;
            sop_q <= push_sop;
            eop_q <= push_eop;
        end else if (src_rdy) begin
            vld_q <= 1'b0;
        end
    end

endmodule

// File: rtl/header_remover.sv
// Strips and checks the fixed header of each message, forwarding payload with sop moved up.
// Latency 1 cycle (payload beat accepted at N appears at N+1) through one register slice.
// Backpressure: snk_rdy = ~slice_full | src_rdy in every state; nothing is skid-buffered.
module header_remover
    import aes_top_pack::*;
#(
    parameter int DATA_W           = 32,
    parameter int HEADER_BITS      = HEADER_BITS_DEF,
    parameter bit DROP_ON_MISMATCH = 1'b1,
    parameter int CNT_W            = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [DATA_W-1:0]      snk_dat,
    input  logic                   snk_vld,
    input  logic                   snk_sop,
    input  logic                   snk_eop,
    output logic                   snk_rdy,
    output logic [DATA_W-1:0]      src_dat,
    output logic                   src_vld,
    output logic                   src_sop,
    output logic                   src_eop,
    input  logic                   src_rdy,
    input  logic [HEADER_BITS-1:0] header_data,
    output logic                   hdr_mismatch,
    output logic                   short_msg,
    output logic                   proto_err,
    output logic [CNT_W-1:0]       msgs_removed
);

    localparam int HDR_WORDS = HEADER_BITS / DATA_W;
    localparam int IDX_W     = (HDR_WORDS > 1) ? $clog2(HDR_WORDS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(HDR_WORDS - 1);

    header_remover_state_t state_q;
    logic [IDX_W-1:0]      hdr_idx_q;
    logic [IDX_W-1:0]      cmp_idx;
    logic                  mis_q;
    logic                  first_q;
    logic                  hdr_mismatch_q;
    logic                  short_msg_q;
    logic                  proto_err_q;
    logic [CNT_W-1:0]      cnt_q;
    logic                  fire;
    logic                  slice_rdy;
    logic                  hdr_beat;
    logic                  restart;
    logic                  word_bad;
    logic                  acc_bad;
    logic                  last_word;
    logic                  push_vld;
    logic [DATA_W-1:0]     exp_word;

    assign fire         = snk_vld & slice_rdy;
    assign snk_rdy      = slice_rdy;
    assign hdr_mismatch = hdr_mismatch_q;
    assign short_msg    = short_msg_q;
    assign proto_err    = proto_err_q;
    assign msgs_removed = cnt_q;

    // A sop seen in HEADER restarts the compare from word 0 with this beat.
    always_comb begin
        restart   = (state_q == IDLE) | snk_sop;
        hdr_beat  = ((state_q == IDLE) & snk_sop) | (state_q == HEADER);
        cmp_idx   = restart ? '0 : hdr_idx_q;
        exp_word  = DATA_W'(hdr_word(HDR_MAX_BITS'(header_data), HEADER_BITS, DATA_W,
                                     int'(cmp_idx)));
        word_bad  = (snk_dat != exp_word);
        acc_bad   = (mis_q & ~restart) | word_bad;
        last_word = (cmp_idx == LAST_IDX);
        push_vld  = fire & (state_q == PAYLOAD);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            hdr_idx_q      <= '0;
            mis_q          <= 1'b0;
            first_q        <= 1'b0;
            hdr_mismatch_q <= 1'b0;
            short_msg_q    <= 1'b0;
            proto_err_q    <= 1'b0;
            cnt_q          <= '0;
        end else begin
            hdr_mismatch_q <= 1'b0;
            short_msg_q    <= 1'b0;
            proto_err_q    <= 1'b0;
            if (fire) begin
                if (hdr_beat) begin
                    hdr_idx_q <= cmp_idx + 1'b1;
                    mis_q     <= acc_bad;
                    if ((state_q == HEADER) && snk_sop) begin
                        proto_err_q <= 1'b1;
                    end
                    if (snk_eop) begin
                        short_msg_q <= 1'b1;
                        state_q     <= IDLE;
                    end else if (last_word) begin
                        first_q <= 1'b1;
                        if (acc_bad) begin
                            hdr_mismatch_q <= 1'b1;
                            if (DROP_ON_MISMATCH) begin
                                state_q <= DROP;
                            end else begin
                                state_q <= PAYLOAD;
                            end
                        end else begin
                            if (cnt_q != '1) begin
                                cnt_q <= cnt_q + 1'b1;
                            end
                            state_q <= PAYLOAD;
                        end
                    end else begin
                        state_q <= HEADER;
                    end
                end else begin
                    case (state_q)
                        IDLE: proto_err_q <= 1'b1;
                        PAYLOAD: begin
                            first_q <= 1'b0;
                            if (snk_sop) begin
                                proto_err_q <= 1'b1;
                            end
                            if (snk_eop) begin
                                state_q <= IDLE;
                            end
                        end
                        DROP: begin
                            if (snk_eop) begin
                                state_q <= IDLE;
                            end
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

    st_reg_slice #(
        .DATA_W (DATA_W)
    ) u_slice (
        .clk      (clk),
        .rst_n    (rst_n),
        .push_vld (push_vld),
        .push_dat (snk_dat),
        .push_sop (first_q),
        .push_eop (snk_eop),
        .push_rdy (slice_rdy),
        .src_vld  (src_vld),
        .src_dat  (src_dat),
        .src_sop  (src_sop),
        .src_eop  (src_eop),
        .src_rdy  (src_rdy)
    );

endmodule

// File: tb/tb_header_remover.sv
// Bench for header_remover: directed scenarios plus randomized backpressure,
// checked against a message-level model (expected beat queues and pulse totals).
module tb_header_remover;

    localparam int DW = 32;
    localparam int HB = 256;
    localparam int HW = HB / DW;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [DW-1:0] snk_dat;
    logic          snk_vld, snk_sop, snk_eop, snk_rdy;
    logic [DW-1:0] src_dat;
    logic          src_vld, src_sop, src_eop, src_rdy;
    logic [HB-1:0] hdr;
    logic          hdr_mismatch, short_msg, proto_err;
    logic [CW-1:0] msgs_removed;

    logic          snk_vld1, snk_rdy1;
    logic [DW-1:0] src_dat1;
    logic          src_vld1, src_sop1, src_eop1, src_rdy1;
    logic          hdr_mismatch1, short_msg1, proto_err1;
    logic [CW-1:0] msgs_removed1;

    always #5 clk = ~clk;

    // The forwarding variant only sees beats the dropping variant accepted.
    assign snk_vld1 = snk_vld & snk_rdy;

    header_remover #(.DATA_W(DW), .HEADER_BITS(HB), .DROP_ON_MISMATCH(1'b1), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .snk_dat(snk_dat), .snk_vld(snk_vld), .snk_sop(snk_sop), .snk_eop(snk_eop), .snk_rdy(snk_rdy),
        .src_dat(src_dat), .src_vld(src_vld), .src_sop(src_sop), .src_eop(src_eop), .src_rdy(src_rdy),
        .header_data(hdr), .hdr_mismatch(hdr_mismatch), .short_msg(short_msg),
        .proto_err(proto_err), .msgs_removed(msgs_removed)
    );

    header_remover #(.DATA_W(DW), .HEADER_BITS(HB), .DROP_ON_MISMATCH(1'b0), .CNT_W(CW)) dut_fwd (
        .clk(clk), .rst_n(rst_n),
        .snk_dat(snk_dat), .snk_vld(snk_vld1), .snk_sop(snk_sop), .snk_eop(snk_eop), .snk_rdy(snk_rdy1),
        .src_dat(src_dat1), .src_vld(src_vld1), .src_sop(src_sop1), .src_eop(src_eop1), .src_rdy(src_rdy1),
        .header_data(hdr), .hdr_mismatch(hdr_mismatch1), .short_msg(short_msg1),
        .proto_err(proto_err1), .msgs_removed(msgs_removed1)
    );

    int n_cmp = 0;
    int n_err = 0;

    logic [DW+1:0] q0[$];
    logic [DW+1:0] q1[$];
    int exp_cnt = 0, exp_mis = 0, exp_short = 0, exp_proto = 0;
    int got_mis = 0, got_short = 0, got_proto = 0;
    int got_mis1 = 0, got_short1 = 0, got_proto1 = 0;
    bit mon_en = 1'b0;
    bit rand_rdy = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Output monitor: sampled on the falling edge, i.e. what the next rising edge will see.
    initial begin
        bit            held;
        logic [DW+1:0] held_beat;
        held = 1'b0;
        held_beat = '0;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                chk("in_ready_rule", {63'd0, snk_rdy}, {63'd0, (!src_vld || src_rdy)});
                chk("in_ready_fwd", {63'd0, snk_rdy1}, 64'd1);
                if (held) begin
                    chk("stall_vld", {63'd0, src_vld}, 64'd1);
                    chk("stall_beat", {30'd0, src_sop, src_eop, src_dat}, {30'd0, held_beat});
                end
                held = src_vld && !src_rdy;
                held_beat = {src_sop, src_eop, src_dat};
                if (src_vld && src_rdy) begin
                    chk("out_beat_expected", {63'd0, q0.size() != 0}, 64'd1);
                    if (q0.size() != 0)
                        chk("out_beat", {30'd0, src_sop, src_eop, src_dat}, {30'd0, q0.pop_front()});
                end
                if (src_vld1) begin
                    chk("fwd_beat_expected", {63'd0, q1.size() != 0}, 64'd1);
                    if (q1.size() != 0)
                        chk("fwd_beat", {30'd0, src_sop1, src_eop1, src_dat1}, {30'd0, q1.pop_front()});
                end
                if (hdr_mismatch === 1'b1) got_mis++;
                if (short_msg === 1'b1) got_short++;
                if (proto_err === 1'b1) got_proto++;
                if (hdr_mismatch1 === 1'b1) got_mis1++;
                if (short_msg1 === 1'b1) got_short1++;
                if (proto_err1 === 1'b1) got_proto1++;
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            src_rdy = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Called just after a rising edge; returns just after the edge on which the beat fired.
    task automatic send_beat(input logic [DW-1:0] d, input logic s, input logic e);
        int w = 0;
        snk_dat = d;
        snk_sop = s;
        snk_eop = e;
        snk_vld = 1'b1;
        @(negedge clk);
        while (!snk_rdy && w < 500) begin
            w++;
            @(negedge clk);
        end
        if (!snk_rdy) chk("snk_rdy_timeout", {63'd0, snk_rdy}, 64'd1);
        @(posedge clk);
        #1;
        snk_vld = 1'b0;
    endtask

    // Model: a message longer than the header yields its payload beats (sop on the first,
    // eop on the last); shorter ones only a short_msg pulse.
    task automatic send_msg(input int len, input int bad_idx, input int sop_at,
                            input bit lat_chk, input int trunc);
        logic [DW-1:0] beats[$];
        logic [DW-1:0] d;
        bit            mis;
        int            nsend;
        nsend = (trunc > 0) ? trunc : len;
        mis = (bad_idx >= 0) && (bad_idx < HW);
        for (int i = 0; i < len; i++) begin
            if (i < HW) begin
                d = hdr[HB-1-i*DW -: DW];
                if (i == bad_idx) d = d ^ 32'h0000_0100;
            end else begin
                d = $urandom;
            end
            beats.push_back(d);
        end
        if (len <= HW) begin
            exp_short++;
        end else begin
            if (mis) exp_mis++;
            else exp_cnt++;
            if (sop_at >= HW) exp_proto++;
            for (int i = HW; i < len; i++) begin
                if (!mis) q0.push_back({i == HW, i == len - 1, beats[i]});
                q1.push_back({i == HW, i == len - 1, beats[i]});
            end
        end
        for (int i = 0; i < nsend; i++) begin
            send_beat(beats[i], (i == 0) || (i == sop_at), i == len - 1);
            if (lat_chk && i == HW - 1 && len > HW)
                chk("hdr_mismatch_timing", {63'd0, hdr_mismatch}, {63'd0, mis});
            if (lat_chk && i == HW && !mis) begin
                chk("first_out_vld", {63'd0, src_vld}, 64'd1);
                chk("first_out_beat", {30'd0, src_sop, src_eop, src_dat},
                    {30'd0, 1'b1, len == HW + 1, beats[HW]});
            end
        end
    endtask

    task automatic check_totals(input string tag);
        for (int i = 0; i < 400 && (q0.size() != 0 || q1.size() != 0); i++) @(posedge clk);
        repeat (3) @(posedge clk);
        #1;
        chk({tag, "_q_drained"}, 64'(q0.size()), 64'd0);
        chk({tag, "_fwd_q_drained"}, 64'(q1.size()), 64'd0);
        chk({tag, "_msgs_removed"}, 64'(msgs_removed), 64'(exp_cnt));
        chk({tag, "_fwd_msgs_removed"}, 64'(msgs_removed1), 64'(exp_cnt));
        chk({tag, "_hdr_mismatch_pulses"}, 64'(got_mis), 64'(exp_mis));
        chk({tag, "_fwd_hdr_mismatch_pulses"}, 64'(got_mis1), 64'(exp_mis));
        chk({tag, "_short_msg_pulses"}, 64'(got_short), 64'(exp_short));
        chk({tag, "_proto_err_pulses"}, 64'(got_proto), 64'(exp_proto));
        chk({tag, "_fwd_short_pulses"}, 64'(got_short1), 64'(exp_short));
        chk({tag, "_fwd_proto_pulses"}, 64'(got_proto1), 64'(exp_proto));
    endtask

    initial begin
        int len, bad;
        hdr = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        snk_dat = '0;
        snk_vld = 1'b0;
        snk_sop = 1'b0;
        snk_eop = 1'b0;
        src_rdy = 1'b1;
        src_rdy1 = 1'b1;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_src_vld", {63'd0, src_vld}, 64'd0);
        chk("rst_src_sop", {63'd0, src_sop}, 64'd0);
        chk("rst_src_eop", {63'd0, src_eop}, 64'd0);
        chk("rst_src_dat", 64'(src_dat), 64'd0);
        chk("rst_pulses", {61'd0, hdr_mismatch, short_msg, proto_err}, 64'd0);
        chk("rst_msgs_removed", 64'(msgs_removed), 64'd0);
        chk("rst_fwd_src_vld", {63'd0, src_vld1}, 64'd0);
        rst_n = 1'b1;
        mon_en = 1'b1;
        @(posedge clk);
        #1;

        // Good header plus four payload beats.
        send_msg(HW + 4, -1, -1, 1'b1, 0);
        check_totals("good");

        // Header word 3 corrupted: dropped here, forwarded by the other variant.
        send_msg(HW + 4, 3, -1, 1'b1, 0);
        check_totals("mismatch");

        // eop on header word 4, then a clean message.
        send_msg(5, -1, -1, 1'b0, 0);
        send_msg(HW + 4, -1, -1, 1'b1, 0);
        check_totals("short");

        // Exactly zero payload beats is also short.
        send_msg(HW, -1, -1, 1'b0, 0);
        check_totals("zero_payload");

        // Stray beat in IDLE, then sop inside the payload.
        exp_proto++;
        send_beat(32'hDEAD_BEEF, 1'b0, 1'b0);
        send_msg(HW + 4, -1, HW + 1, 1'b0, 0);
        check_totals("proto");

        // Reset while the second payload beat is presented.
        send_msg(HW + 4, -1, -1, 1'b0, HW + 1);
        rst_n = 1'b0;
        snk_dat = 32'h1234_5678;
        snk_sop = 1'b0;
        snk_eop = 1'b0;
        snk_vld = 1'b1;
        @(posedge clk);
        #1;
        snk_vld = 1'b0;
        q0.delete();
        q1.delete();
        exp_cnt = 0;
        chk("midrst_src_vld", {63'd0, src_vld}, 64'd0);
        chk("midrst_src_dat", 64'(src_dat), 64'd0);
        chk("midrst_msgs_removed", 64'(msgs_removed), 64'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        send_msg(HW + 3, -1, -1, 1'b1, 0);
        check_totals("after_reset");

        // Random lengths, occasional bad headers, random downstream stalls.
        rand_rdy = 1'b1;
        for (int m = 0; m < 100; m++) begin
            len = $urandom_range(1, 14);
            bad = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, HW - 1)) : -1;
            send_msg(len, bad, -1, 1'b0, 0);
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end
        end
        rand_rdy = 1'b0;
        check_totals("random");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
